// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational memory address, and a registered IF/ID word. Fetch latency is 1 cycle.
// Stall holds PC and the buffer. A redirect overrides stall and inserts one bubble. A bad next PC halts the unit until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] PC,
   input  logic [31:0] Instr_in,
   input  logic        Stall,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_target,
   input  logic        Jump,
   input  logic [25:0] Jump_index,
   output logic [31:0] Instr_out,
   output logic [31:0] PC_plus4_out,
   output logic        Valid_out,
   output logic [31:0] Fetch_count,
   output logic        Fault
);

   localparam logic [31:0] MAX_PC = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_inc;
   logic [31:0] next_pc;
   logic        redirect;
   logic        bad_pc;
   logic        load_word;
   logic        load_bubble;
   logic        take_pc;
   logic        set_fault;

   assign pc_inc   = PC + 32'd4;
   assign redirect = Jump | Branch_taken;

   always_comb begin
      next_pc = pc_inc;
      if (Jump)
         next_pc = {PC_plus4_out[31:28], Jump_index, 2'b00};
      else if (Branch_taken)
         next_pc = Branch_target;
      else if (Stall)
         next_pc = PC;
   end

   assign bad_pc = (next_pc[1:0] != 2'b00) || (next_pc > MAX_PC);

   // The offending PC is never loaded, so PC keeps its last good value in HALT.
   always_comb begin
      state_nxt   = state;
      load_word   = 1'b0;
      load_bubble = 1'b0;
      take_pc     = 1'b0;
      set_fault   = 1'b0;
      case (state)
         IDLE: begin
            state_nxt   = RUN;
            load_bubble = 1'b1;
         end
         RUN: begin
            if (bad_pc) begin
               state_nxt   = HALT;
               load_bubble = 1'b1;
               set_fault   = 1'b1;
            end else if (redirect) begin
               load_bubble = 1'b1;
               take_pc     = 1'b1;
            end else if (!Stall) begin
               load_word = 1'b1;
               take_pc   = 1'b1;
            end
         end
         default: begin
            state_nxt = state;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         PC           <= RESET_PC;
         Instr_out    <= 32'd0;
         PC_plus4_out <= 32'd0;
         Valid_out    <= 1'b0;
         Fetch_count  <= 32'd0;
         Fault        <= 1'b0;
      end else begin
         if (take_pc)
            PC <= next_pc;
         if (load_word) begin
            Instr_out    <= Instr_in;
            PC_plus4_out <= pc_inc;
            Valid_out    <= 1'b1;
            Fetch_count  <= Fetch_count + 32'd1;
         end else if (load_bubble) begin
            Instr_out <= 32'd0;
            Valid_out <= 1'b0;
         end
         if (set_fault)
            Fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-edge stimulus and expected outputs, plus an async reset sequence.
module tb_fetch_unit;

   logic        CLK;
   logic        RST;
   logic [31:0] PC;
   logic [31:0] Instr_in;
   logic        Stall;
   logic        Branch_taken;
   logic [31:0] Branch_target;
   logic        Jump;
   logic [25:0] Jump_index;
   logic [31:0] Instr_out;
   logic [31:0] PC_plus4_out;
   logic        Valid_out;
   logic [31:0] Fetch_count;
   logic        Fault;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_BYTES(1024)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .PC           (PC),
      .Instr_in     (Instr_in),
      .Stall        (Stall),
      .Branch_taken (Branch_taken),
      .Branch_target(Branch_target),
      .Jump         (Jump),
      .Jump_index   (Jump_index),
      .Instr_out    (Instr_out),
      .PC_plus4_out (PC_plus4_out),
      .Valid_out    (Valid_out),
      .Fetch_count  (Fetch_count),
      .Fault        (Fault)
   );

   assign Instr_in = mem[PC[9:2]];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic [25:0] jidx;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] p4;
      logic        v;
      logic [31:0] cnt;
      logic        f;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] bt, logic jmp,
                               logic [25:0] jidx, logic [31:0] pc, logic [31:0] instr,
                               logic [31:0] p4, logic v, logic [31:0] cnt, logic f);
      vec_t r;
      r.rst = rst; r.stall = stall; r.br = br; r.bt = bt; r.jmp = jmp; r.jidx = jidx;
      r.pc = pc; r.instr = instr; r.p4 = p4; r.v = v; r.cnt = cnt; r.f = f;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h, required %h", name, row, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int row, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] p4, input logic v, input logic [31:0] cnt, input logic f);
      chk({tag, ".pc"},    row, PC, pc);
      chk({tag, ".instr"}, row, Instr_out, instr);
      chk({tag, ".p4"},    row, PC_plus4_out, p4);
      chk({tag, ".valid"}, row, {31'd0, Valid_out}, {31'd0, v});
      chk({tag, ".count"}, row, Fetch_count, cnt);
      chk({tag, ".fault"}, row, {31'd0, Fault}, {31'd0, f});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
      mem[0] = 32'h2008_0001;
      mem[1] = 32'h2009_0002;
      mem[2] = 32'h0109_5020;

      RST = 1'b0; Stall = 1'b0; Branch_taken = 1'b0; Branch_target = 32'd0;
      Jump = 1'b0; Jump_index = 26'd0;

      //          rst stl br bt            jmp jidx      pc            instr          p4            v  cnt  f
      // sequential fetch
      vq.push_back(mk(1, 0, 0, 32'h0,    0, 26'h0,  32'h0,    32'h0,         32'h0,    0, 0, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h4,    32'h2008_0001, 32'h4,    1, 1, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h8,    32'h2009_0002, 32'h8,    1, 2, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'hC,    32'h0109_5020, 32'hC,    1, 3, 0));
      // branch together with stall at PC = 8
      vq.push_back(mk(1, 0, 0, 32'h0,    0, 26'h0,  32'h0,    32'h0,         32'h0,    0, 0, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h4,    32'h2008_0001, 32'h4,    1, 1, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h8,    32'h2009_0002, 32'h8,    1, 2, 0));
      vq.push_back(mk(0, 1, 1, 32'h40,   0, 26'h0,  32'h40,   32'h0,         32'h8,    0, 2, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h44,   32'hA000_0010, 32'h44,   1, 3, 0));
      // jump beats branch: single bubble then target stream
      vq.push_back(mk(0, 0, 1, 32'h100,  1, 26'h20, 32'h80,   32'h0,         32'h44,   0, 3, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h84,   32'hA000_0020, 32'h84,   1, 4, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h88,   32'hA000_0021, 32'h88,   1, 5, 0));
      // reach PC = 0x14, then stall three cycles
      vq.push_back(mk(0, 0, 1, 32'h10,   0, 26'h0,  32'h10,   32'h0,         32'h88,   0, 5, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h14,   32'hA000_0004, 32'h14,   1, 6, 0));
      vq.push_back(mk(0, 1, 0, 32'h0,    0, 26'h0,  32'h14,   32'hA000_0004, 32'h14,   1, 6, 0));
      vq.push_back(mk(0, 1, 0, 32'h0,    0, 26'h0,  32'h14,   32'hA000_0004, 32'h14,   1, 6, 0));
      vq.push_back(mk(0, 1, 0, 32'h0,    0, 26'h0,  32'h14,   32'hA000_0004, 32'h14,   1, 6, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h18,   32'hA000_0005, 32'h18,   1, 7, 0));
      // misaligned branch target faults; later redirects are ignored
      vq.push_back(mk(0, 0, 1, 32'h42,   0, 26'h0,  32'h18,   32'h0,         32'h18,   0, 7, 1));
      vq.push_back(mk(0, 0, 1, 32'h40,   1, 26'h10, 32'h18,   32'h0,         32'h18,   0, 7, 1));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'h18,   32'h0,         32'h18,   0, 7, 1));
      // sequential fetch off the end of memory
      vq.push_back(mk(1, 0, 0, 32'h0,    0, 26'h0,  32'h0,    32'h0,         32'h0,    0, 0, 0));
      vq.push_back(mk(0, 0, 1, 32'd1016, 0, 26'h0,  32'd1016, 32'h0,         32'h0,    0, 0, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'd1020, 32'hA000_00FE, 32'd1020, 1, 1, 0));
      vq.push_back(mk(0, 0, 0, 32'h0,    0, 26'h0,  32'd1020, 32'h0,         32'd1020, 0, 1, 1));

      #1;
      chk_all("reset", -1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;

      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].rst) begin
            RST = 1'b0;
            #2;
            RST = 1'b1;
         end
         Stall         = vq[i].stall;
         Branch_taken  = vq[i].br;
         Branch_target = vq[i].bt;
         Jump          = vq[i].jmp;
         Jump_index    = vq[i].jidx;
         @(posedge CLK);
         #1;
         chk_all("tbl", i, vq[i].pc, vq[i].instr, vq[i].p4, vq[i].v, vq[i].cnt, vq[i].f);
      end

      // async reset between edges while a valid word is held
      Stall = 1'b0; Branch_taken = 1'b0; Jump = 1'b0;
      RST = 1'b0;
      #2;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_all("prerst", 100, 32'h8, 32'h2009_0002, 32'h8, 1'b1, 32'h2, 1'b0);
      #2;
      RST = 1'b0;
      #1;
      chk_all("async", 101, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge CLK);
      #1;
      chk_all("held", 102, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      RST = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
